// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 8-bit ALU core: opcodes, ALU select codes, field positions, latencies.
// No logic and no latency; the types and constants here are used by both the decode and the issue controller.
package cpu_isa_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int REG_ADDR_W_DEF = 3;
  localparam int INSTR_W_DEF    = 32;
  localparam int FAST_LAT_DEF   = 1;
  localparam int SLOW_LAT_DEF   = 2;

  localparam int FIELD_W  = 8;
  localparam int OP_LSB   = 24;
  localparam int DEST_LSB = 16;
  localparam int SRC1_LSB = 8;
  localparam int SRC2_LSB = 0;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_MULT  = 8'h08;
  localparam logic [7:0] OP_SLL   = 8'h09;
  localparam logic [7:0] OP_SRL   = 8'h0A;
  localparam logic [7:0] OP_SRA   = 8'h0B;
  localparam logic [7:0] OP_ROR   = 8'h0C;

  typedef enum logic [2:0] {
    ALU_FWD   = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_MUL   = 3'b100,
    ALU_SHIFT = 3'b101,
    ALU_SRA   = 3'b110,
    ALU_ROR   = 3'b111
  } aluop_e;

  typedef enum logic {LAT_FAST, LAT_SLOW} lat_e;

  typedef enum logic [1:0] {KIND_WB, KIND_JMP, KIND_BEQ, KIND_ILL} kind_e;

  typedef enum logic [2:0] {ST_IDLE, ST_EXEC, ST_WB, ST_BR, ST_ERR} state_e;

  typedef struct packed {
    aluop_e aluop;
    logic   imm_sel;
    logic   neg_sel;
    lat_e   lat;
    kind_e  kind;
  } dec_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Opcode decode: OP byte to ALU select, operand muxing, latency class and completion kind.
// Purely combinational, zero latency; no handshake of its own.
module alu_issue_decode
  import cpu_isa_pkg::*;
(
  input  logic [7:0] op_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{aluop: ALU_FWD, imm_sel: 1'b0, neg_sel: 1'b0, lat: LAT_SLOW, kind: KIND_WB};
    case (op_i)
      OP_LOADI: begin dec_o.imm_sel = 1'b1; dec_o.lat = LAT_FAST; end
      OP_MOV:   dec_o.lat = LAT_FAST;
      OP_ADD:   dec_o.aluop = ALU_ADD;
      OP_SUB:   begin dec_o.aluop = ALU_ADD; dec_o.neg_sel = 1'b1; end
      OP_AND:   begin dec_o.aluop = ALU_AND; dec_o.lat = LAT_FAST; end
      OP_OR:    begin dec_o.aluop = ALU_OR;  dec_o.lat = LAT_FAST; end
      OP_J:     dec_o.kind = KIND_JMP;
      OP_BEQ:   begin dec_o.aluop = ALU_ADD; dec_o.neg_sel = 1'b1; dec_o.kind = KIND_BEQ; end
      OP_MULT:  dec_o.aluop = ALU_MUL;
      OP_SLL:   begin dec_o.aluop = ALU_SHIFT; dec_o.imm_sel = 1'b1; end
      // Right-direction shifts/rotates hand the ALU a negated shift amount.
      OP_SRL:   begin dec_o.aluop = ALU_SHIFT; dec_o.imm_sel = 1'b1; dec_o.neg_sel = 1'b1; end
      OP_SRA:   begin dec_o.aluop = ALU_SRA;   dec_o.imm_sel = 1'b1; dec_o.neg_sel = 1'b1; end
      OP_ROR:   begin dec_o.aluop = ALU_ROR;   dec_o.imm_sel = 1'b1; dec_o.neg_sel = 1'b1; end
      default:  dec_o.kind = KIND_ILL;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: accepts one instruction, holds decode fields, times ALU latency, then pulses write-back/branch/illegal.
// Latency: fast op WB 1 cycle after accept, slow op 2, j/illegal immediate; INSTR_READY only while idle.
module alu_issue_ctrl
  import cpu_isa_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int FAST_LAT   = FAST_LAT_DEF,
  parameter int SLOW_LAT   = SLOW_LAT_DEF
)
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [INSTR_W-1:0]    INSTR,
  input  logic                  INSTR_VALID,
  output logic                  INSTR_READY,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [DATA_W-1:0]     IMMEDIATE,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic [2:0]            ALUOP,
  input  logic                  ALU_ZERO,
  output logic                  WRITEENABLE,
  output logic                  BRANCH_TAKEN,
  output logic [DATA_W-1:0]     BRANCH_OFFSET,
  output logic                  ILLEGAL
);

  localparam int MAX_LAT = (SLOW_LAT > FAST_LAT) ? SLOW_LAT : FAST_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e                state_q, state_d;
  kind_e                 kind_q, kind_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  taken_q, taken_d;
  dec_t                  dec;
  logic [7:0]            op;
  logic                  accept;
  logic [REG_ADDR_W-1:0] rr1_q, rr2_q, wr_q;
  logic [DATA_W-1:0]     imm_q, off_q;
  logic                  imm_sel_q, neg_sel_q;
  logic [2:0]            aluop_q;
  logic                  unused_src1_hi;

  assign op     = INSTR[OP_LSB +: FIELD_W];
  assign accept = INSTR_VALID && (state_q == ST_IDLE);
  assign unused_src1_hi = ^INSTR[SRC1_LSB + REG_ADDR_W +: FIELD_W - REG_ADDR_W];

  alu_issue_decode u_decode (
    .op_i  (op),
    .dec_o (dec)
  );

  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    cnt_d   = cnt_q;
    taken_d = taken_q;
    case (state_q)
      ST_IDLE: begin
        if (INSTR_VALID) begin
          kind_d = dec.kind;
          case (dec.kind)
            KIND_ILL: state_d = ST_ERR;
            KIND_JMP: begin state_d = ST_BR; taken_d = 1'b1; end
            default: begin
              state_d = ST_EXEC;
              cnt_d   = (dec.lat == LAT_SLOW) ? CNT_W'(SLOW_LAT - 1) : CNT_W'(FAST_LAT - 1);
            end
          endcase
        end
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          if (kind_q == KIND_BEQ) begin
            state_d = ST_BR;
            taken_d = ALU_ZERO;
          end else begin
            state_d = ST_WB;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_BR: begin
        state_d = ST_IDLE;
        taken_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      kind_q  <= KIND_WB;
      cnt_q   <= '0;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      cnt_q   <= cnt_d;
      taken_q <= taken_d;
    end
  end

  // Decode fields are captured once at accept and held until the next accept.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rr1_q     <= '0;
      rr2_q     <= '0;
      wr_q      <= '0;
      imm_q     <= '0;
      off_q     <= '0;
      imm_sel_q <= 1'b0;
      neg_sel_q <= 1'b0;
      aluop_q   <= '0;
    end else if (accept) begin
      rr1_q     <= INSTR[SRC1_LSB +: REG_ADDR_W];
      rr2_q     <= INSTR[SRC2_LSB +: REG_ADDR_W];
      wr_q      <= INSTR[DEST_LSB +: REG_ADDR_W];
      imm_q     <= INSTR[SRC2_LSB +: DATA_W];
      off_q     <= INSTR[DEST_LSB +: DATA_W];
      imm_sel_q <= dec.imm_sel;
      neg_sel_q <= dec.neg_sel;
      aluop_q   <= dec.aluop;
    end
  end

  assign INSTR_READY   = (state_q == ST_IDLE);
  assign WRITEENABLE   = (state_q == ST_WB);
  assign ILLEGAL       = (state_q == ST_ERR);
  assign BRANCH_TAKEN  = (state_q == ST_BR) && taken_q;
  assign READREG1      = rr1_q;
  assign READREG2      = rr2_q;
  assign WRITEREG      = wr_q;
  assign IMMEDIATE     = imm_q;
  assign BRANCH_OFFSET = off_q;
  assign IMM_SEL       = imm_sel_q;
  assign NEG_SEL       = neg_sel_q;
  assign ALUOP         = aluop_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Instruction-side control for the 8-bit ALU: accepts 32-bit instruction words over a valid/ready handshake and decodes them into ALU select, register-file read/write addresses, immediate and negate controls.
- Sequences the fixed ALU latency, then issues a one-cycle register write-back or a branch decision from the ALU ZERO flag.
- Sits between the instruction fetch stage and the register file/ALU datapath.

Parameters:
- DATA_W, 8, datapath/immediate width.
- REG_ADDR_W, 3, register address width.
- INSTR_W, 32, instruction width.
- FAST_LAT, 1, exec cycles for mov/loadi/and/or.
- SLOW_LAT, 2, exec cycles for add/sub/beq/mult/shift/rotate.

Ports:
- CLK  in  1  clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- INSTR  in  INSTR_W  instruction word: OP[31:24], DEST[23:16], SRC1[15:8], SRC2[7:0].
- INSTR_VALID  in  1  instruction present.
- INSTR_READY  out  1  controller can accept.
- READREG1  out  REG_ADDR_W  SRC1[2:0].
- READREG2  out  REG_ADDR_W  SRC2[2:0].
- WRITEREG  out  REG_ADDR_W  DEST[2:0].
- IMMEDIATE  out  DATA_W  SRC2 byte.
- IMM_SEL  out  1  ALU DATA2 = IMMEDIATE (else register).
- NEG_SEL  out  1  ALU DATA2 is two's-complement negated.
- ALUOP  out  3  ALU select code.
- ALU_ZERO  in  1  ALU zero flag.
- WRITEENABLE  out  1  register write-back strobe.
- BRANCH_TAKEN  out  1  one-cycle branch pulse.
- BRANCH_OFFSET  out  DATA_W  signed word offset (DEST byte).
- ILLEGAL  out  1  one-cycle pulse on an undefined opcode.

Behaviour:
- Interface fixed: one clock (CLK); RESET is asynchronous and active-high.
- Reset: state IDLE. All outputs 0 except INSTR_READY=1. Reset mid-operation aborts with no WRITEENABLE or BRANCH_TAKEN pulse.
- FSM states: IDLE, EXEC, WB, BR, ERR.
- INSTR_READY=1 only in IDLE.
- Accept occurs on a rising edge with INSTR_VALID&&INSTR_READY. At that edge all decode outputs register and hold stable until the return to IDLE.
- Decode table (OP -> ALUOP, IMM_SEL, NEG_SEL, latency, next state):
  - 0x00 loadi -> 000, 1, 0, FAST, WB.
  - 0x01 mov -> 000, 0, 0, FAST, WB.
  - 0x02 add -> 001, 0, 0, SLOW, WB.
  - 0x03 sub -> 001, 0, 1, SLOW, WB.
  - 0x04 and -> 010, 0, 0, FAST, WB.
  - 0x05 or -> 011, 0, 0, FAST, WB.
  - 0x06 j -> 000, 0, 0, none, BR (taken).
  - 0x07 beq -> 001, 0, 1, SLOW, BR (conditional).
  - 0x08 mult -> 100, 0, 0, SLOW, WB.
  - 0x09 sll -> 101, 1, 0, SLOW, WB.
  - 0x0A srl -> 101, 1, 1, SLOW, WB.
  - 0x0B sra -> 110, 1, 1, SLOW, WB.
  - 0x0C ror -> 111, 1, 1, SLOW, WB.
  - Any other OP -> ERR.
- Right shifts/rotates set NEG_SEL so the ALU sees a negative amount (right direction).
- EXEC: a down-counter loaded with latency-1 at accept. Leave EXEC when the counter is 0.
- WB: WRITEENABLE=1 for exactly one cycle, then IDLE.
- BR:
  - For j: BRANCH_TAKEN=1 for one cycle, entered directly from accept.
  - For beq: BRANCH_TAKEN equals ALU_ZERO sampled on the last EXEC edge, one cycle.
  - Then IDLE. BRANCH_OFFSET holds DEST throughout.
- ERR: ILLEGAL=1 for one cycle, then IDLE. No write, no branch.
- Timing from accept edge E0:
  - Fast op: WRITEENABLE high in [E1,E2), READY at E2.
  - Slow op: WRITEENABLE high in [E2,E3), READY at E3.
  - j: pulse in [E0,E1).
- INSTR changes while not ready are ignored. VALID held through IDLE is accepted on the first IDLE edge, so back-to-back instructions are separated by one IDLE cycle.
- Upper DEST/SRC bits beyond REG_ADDR_W are ignored for register addresses.
- WRITEENABLE, BRANCH_TAKEN and ILLEGAL are mutually exclusive and never high in IDLE.

Decomposition:
- Shared package `cpu_isa_pkg`:
  - Opcode constants.
  - ALUOP codes (matching ALU select 000–111).
  - Instruction field bit positions.
  - FAST_LAT/SLOW_LAT defaults.
- Sub-module `alu_issue_decode`: purely combinational OP -> {ALUOP, IMM_SEL, NEG_SEL, latency class, kind}.

Test Plan:
- Reset/loadi: reset asserted mid-EXEC of add -> all outputs 0, READY=1, no WRITEENABLE. Then INSTR=0x00030012 -> WRITEREG=3, IMMEDIATE=0x12, IMM_SEL=1, ALUOP=000, WRITEENABLE one cycle at E1.
- Slow op: sub INSTR=0x03020105 -> READREG1=1, READREG2=5, WRITEREG=2, ALUOP=001, NEG_SEL=1, WRITEENABLE only in [E2,E3), READY low for 3 cycles.
- beq: INSTR=0x07FC0102 with ALU_ZERO=1 at the last EXEC edge -> BRANCH_TAKEN pulse, OFFSET=0xFC. Repeat with ALU_ZERO=0 -> no pulse, no WRITEENABLE.
- Shifts: srl INSTR=0x0A040103 -> ALUOP=101, IMM_SEL=1, NEG_SEL=1, IMMEDIATE=0x03. ror 0x0C… -> ALUOP=111, NEG_SEL=1.
- Illegal/j: OP=0xFF -> ILLEGAL one cycle, no write. j INSTR=0x06050000 -> BRANCH_TAKEN in [E0,E1), OFFSET=0x05.
- Handshake: VALID held high across three fast ops -> each accepted exactly once. INSTR toggled while READY=0 has no effect.
